// File: rtl/run_ctrl_pkg.sv
// Shared types and default widths for the run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package run_ctrl_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_CW = 16;

  // Start-pulse counter width; holds START_CYC values 1..7.
  localparam int SCW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/run_timer.sv
// Saturating run-cycle counter with clear/enable and a next-count limit compare.
// Latency: count updates on the edge after en; hit is combinational from cnt and lim.
// Backpressure: none; en simply freezes the count.
module run_timer
  import run_ctrl_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] lim,
  output logic [CW-1:0] cnt,
  output logic          hit
);

  // One extra bit so the saturated value never aliases onto a small limit.
  logic [CW:0] cnt_inc;
  logic        sat;

  assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  assign sat     = &cnt;
  // A zero limit disables the compare.
  assign hit     = (lim != '0) && (cnt_inc == {1'b0, lim});

  // Count register: clear wins, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: host preload/readback of dat_mem, CPU start pulse, cycle/timeout tracking.
// Latency: memory mux is combinational; host read data returns one cycle after grant.
// Backpressure: host requests are refused (host_gnt=0) while the CPU owns the memory port.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int CW        = DEF_CW,
  parameter int START_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          host_go,
  input  logic          host_wr_req,
  input  logic          host_rd_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          cpu_start,
  input  logic          cpu_done,
  input  logic          cpu_mem_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic [CW-1:0] timeout_lim,
  output logic [CW-1:0] cycle_cnt,
  output logic          busy,
  output logic          finished,
  output logic          timeout
);

  localparam logic [SCW-1:0] START_LD = SCW'(START_CYC);

  state_t         state, state_nxt;
  logic [SCW-1:0] start_cnt;
  logic           go_acc;
  logic           tmr_en;
  logic           tmr_hit;
  logic           timeout_set;
  logic           host_own;
  logic           rd_acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode; cpu_done beats the timeout hit.
  always_comb begin
    state_nxt   = state;
    go_acc      = 1'b0;
    tmr_en      = 1'b0;
    timeout_set = 1'b0;
    cpu_start   = 1'b0;
    busy        = 1'b0;
    finished    = 1'b0;
    case (state)
      IDLE: begin
        if (host_go) begin
          state_nxt = START;
          go_acc    = 1'b1;
        end
      end
      START: begin
        cpu_start = 1'b1;
        busy      = 1'b1;
        if (start_cnt <= SCW'(1)) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cpu_done) begin
          state_nxt = DONE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_hit) begin
            state_nxt   = DONE;
            timeout_set = 1'b1;
          end
        end
      end
      DONE: begin
        finished = 1'b1;
        if (host_go) begin
          state_nxt = START;
          go_acc    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Start-pulse length counter, loaded when a run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
    end else if (go_acc) begin
      start_cnt <= START_LD;
    end else if (state == START && start_cnt != '0) begin
      start_cnt <= start_cnt - SCW'(1);
    end
  end

  // Timeout flag: cleared at run accept, set when the limit ends the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (go_acc) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end
  end

  run_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_acc),
    .en    (tmr_en),
    .lim   (timeout_lim),
    .cnt   (cycle_cnt),
    .hit   (tmr_hit)
  );

  // Memory port mux; CPU stores outside START/RUN are discarded.
  always_comb begin
    host_own  = (state == IDLE) || (state == DONE);
    host_gnt  = 1'b0;
    rd_acc    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr_en = cpu_mem_wr;
    if (host_own) begin
      host_gnt  = host_wr_req | host_rd_req;
      rd_acc    = host_rd_req & ~host_wr_req;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr_en = host_wr_req;
    end
  end

  // Host read capture and one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= rd_acc;
      if (rd_acc) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_go = 1'b0;
  logic        host_wr_req = 1'b0;
  logic        host_rd_req = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_gnt;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        cpu_start;
  logic        cpu_done = 1'b0;
  logic        cpu_mem_wr = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [15:0] timeout_lim = '0;
  logic [15:0] cycle_cnt;
  logic        busy;
  logic        finished;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // dat_mem stand-in: combinational read, write on rising edge.
  logic [7:0] mem [0:255];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  run_ctrl #(.AW(8), .DW(8), .CW(16), .START_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .host_go(host_go),
    .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .cpu_mem_wr(cpu_mem_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .timeout_lim(timeout_lim), .cycle_cnt(cycle_cnt),
    .busy(busy), .finished(finished), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop: rvalid must be up now with the oldest expected word.
  task automatic chk_rvalid(input string tag);
    logic [7:0] e;
    chk({tag, "_rvalid"}, host_rvalid, 1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=pending", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, host_rdata, e);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    host_wr_req = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk({tag, "_gnt"}, host_gnt, 1);
    chk({tag, "_wren"}, mem_wr_en, 1);
    tick();
    host_wr_req = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] e, input string tag);
    host_rd_req = 1'b1; host_addr = a;
    exp_q.push_back(e);
    #1;
    chk({tag, "_gnt"}, host_gnt, 1);
    tick();
    host_rd_req = 1'b0;
    chk_rvalid(tag);
    tick();
    chk({tag, "_pulse"}, host_rvalid, 0);
  endtask

  // Count cpu_start cycles (bounded), starting with the current sample.
  task automatic count_start(input string tag);
    int n = 0;
    int k = 0;
    while (cpu_start === 1'b1 && k < 10) begin
      n++; k++;
      tick();
    end
    chk({tag, "_len"}, n, 2);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic go_run(input string tag);
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    count_start(tag);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (cycle_cnt !== target && n < budget) begin
      tick(); n++;
    end
    chk({tag, "_reach"}, cycle_cnt, target);
  endtask

  task automatic wait_finished(input int budget, input string tag);
    int n = 0;
    while (finished !== 1'b1 && n < budget) begin
      tick(); n++;
    end
    chk({tag, "_fin"}, finished, 1);
  endtask

  initial begin
    // Reset values.
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_fin", finished, 0);
    chk("rst_start", cpu_start, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_to", timeout, 0);
    chk("rst_rv", host_rvalid, 0);
    chk("rst_rd", host_rdata, 0);
    #3 rst_n = 1'b1;
    tick();

    // Preload and readback.
    host_write(8'h10, 8'hA5, "wr10");
    host_write(8'h20, 8'h5C, "wr20");
    host_read(8'h10, 8'hA5, "rd10");

    // Write and read together: write lands, read dropped.
    host_wr_req = 1'b1; host_rd_req = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
    tick();
    host_wr_req = 1'b0; host_rd_req = 1'b0;
    chk("wrrd_norv", host_rvalid, 0);
    host_read(8'h30, 8'h77, "rd30");

    // CPU store while host owns the port is dropped.
    cpu_mem_wr = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hFF; host_addr = 8'h40;
    #1;
    chk("idle_cpuwr", mem_wr_en, 0);
    chk("idle_addr", mem_addr, 8'h40);
    tick();
    cpu_mem_wr = 1'b0;
    host_read(8'h10, 8'hA5, "rd10b");

    // Run with coincident host read in IDLE.
    timeout_lim = 16'd1000;
    host_go = 1'b1; host_rd_req = 1'b1; host_addr = 8'h10;
    exp_q.push_back(8'hA5);
    #1;
    chk("go_gnt", host_gnt, 1);
    tick();
    host_go = 1'b0; host_rd_req = 1'b0;
    chk_rvalid("go_rd");
    count_start("run1");
    chk("run1_cnt0", cycle_cnt, 0);

    // Ownership during RUN.
    host_wr_req = 1'b1; host_addr = 8'h20; host_wdata = 8'hEE;
    cpu_addr = 8'h33; cpu_mem_wr = 1'b0;
    #1;
    chk("run_gnt", host_gnt, 0);
    chk("run_addr", mem_addr, 8'h33);
    chk("run_wren", mem_wr_en, 0);
    tick();
    host_wr_req = 1'b0;
    cpu_mem_wr = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h99;
    #1;
    chk("run_cpuwr", mem_wr_en, 1);
    chk("run_cpudat", mem_wdata, 8'h99);
    tick();
    cpu_mem_wr = 1'b0;

    // Done at count 40.
    wait_cnt(16'd40, 100, "run1");
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("run1_fin", finished, 1);
    chk("run1_busy", busy, 0);
    chk("run1_cnt", cycle_cnt, 40);
    chk("run1_to", timeout, 0);
    tick();
    chk("done_hold", cycle_cnt, 40);
    host_read(8'h20, 8'h5C, "rd20");
    host_read(8'h50, 8'h99, "rd50");

    // Timeout at 100; host_go ignored in RUN.
    timeout_lim = 16'd100;
    go_run("run2");
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick();
    chk("run2_goign", cpu_start, 0);
    wait_finished(200, "run2");
    chk("run2_cnt", cycle_cnt, 100);
    chk("run2_to", timeout, 1);

    // cpu_done beats timeout on the same edge.
    timeout_lim = 16'd20;
    go_run("run3");
    chk("run3_toclr", timeout, 0);
    wait_cnt(16'd19, 50, "run3");
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("run3_fin", finished, 1);
    chk("run3_to", timeout, 0);
    chk("run3_cnt", cycle_cnt, 19);

    // No limit: saturate and stay in RUN.
    timeout_lim = 16'd0;
    go_run("run4");
    wait_cnt(16'hFFFF, 70000, "run4");
    tick(); tick(); tick();
    chk("sat_cnt", cycle_cnt, 16'hFFFF);
    chk("sat_busy", busy, 1);
    chk("sat_fin", finished, 0);
    #2 rst_n = 1'b0;
    #1 chk("sat_rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a run.
    timeout_lim = 16'd1000;
    go_run("run5");
    wait_cnt(16'd5, 20, "run5");
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", cpu_start, 0);
    chk("arst_cnt", cycle_cnt, 0);
    chk("arst_fin", finished, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_busy", busy, 0);
    chk("post_fin", finished, 0);
    host_read(8'h10, 8'hA5, "post_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
